// File: rtl/tetris_ctrl.sv
// Sequencing controller for the tetris datapath: turns buttons and a gravity timer into
// command strobes and walks each piece through spawn, check, play, land, clear and compact.
module tetris_ctrl #(
    parameter int unsigned DROP_TICKS = 25_000_000,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic clk,
    input  logic clr,
    input  logic start,
    input  logic pause,
    input  logic U,
    input  logic D,
    input  logic L,
    input  logic R,
    input  logic move_comp,
    input  logic down_comp,
    input  logic die,
    input  logic remove_2_finish,
    input  logic shift_finish,
    output logic gen_random,
    output logic isdie,
    output logic moveT,
    output logic move_down,
    output logic remove_1,
    output logic remove_2,
    output logic shift,
    output logic u,
    output logic d,
    output logic l,
    output logic r,
    output logic stop,
    output logic auto_down,
    output logic game_over,
    output logic err
);

    localparam int unsigned GW = $clog2(DROP_TICKS);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [GW-1:0] GravMax = GW'(DROP_TICKS - 1);
    localparam logic [TW-1:0] WaitMax = TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        StIdle, StGen, StChk, StPlay, StMove, StDown, StRem1, StRem2, StShift, StOver
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    btn_q, btn_prev_q, btn_edge;  // {U, D, L, R}
    logic          start_prev_q;
    logic          move_comp_q, down_comp_q, rem2_fin_q, shift_fin_q;
    logic [GW-1:0] grav_q, grav_d;
    logic [TW-1:0] wait_q, wait_d;
    logic          chk_q, chk_d;
    logic [3:0]    dir_q, dir_d;                 // {u, d, l, r}
    logic          auto_q, auto_d;
    logic          err_d;
    logic          wait_active, wait_hit, timeout;

    assign btn_edge    = btn_q & ~btn_prev_q;
    assign wait_active = (state_q == StMove) || (state_q == StDown) ||
                         (state_q == StRem2) || (state_q == StShift);
    assign wait_hit    = (wait_q == WaitMax);

    always_comb begin
        state_d = state_q;
        grav_d  = grav_q;
        chk_d   = 1'b0;
        dir_d   = dir_q;
        auto_d  = auto_q;
        err_d   = err;
        timeout = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StGen;
                    err_d   = 1'b0;
                end
            end
            StGen: begin
                grav_d  = '0;
                state_d = StChk;
            end
            StChk: begin
                if (!chk_q) chk_d = 1'b1;
                else        state_d = die ? StOver : StPlay;
            end
            StPlay: begin
                if (!pause) begin
                    if (grav_q == GravMax) begin
                        state_d = StDown;
                        grav_d  = '0;
                        dir_d   = 4'b0100;
                        auto_d  = 1'b1;
                    end else begin
                        grav_d = grav_q + 1'b1;
                        auto_d = 1'b0;
                        // Fixed priority D > U > L > R; losing edges are dropped.
                        if (btn_edge[2]) begin
                            state_d = StDown;
                            dir_d   = 4'b0100;
                        end else if (btn_edge[3]) begin
                            state_d = StMove;
                            dir_d   = 4'b1000;
                        end else if (btn_edge[1]) begin
                            state_d = StMove;
                            dir_d   = 4'b0010;
                        end else if (btn_edge[0]) begin
                            state_d = StMove;
                            dir_d   = 4'b0001;
                        end
                    end
                end
            end
            StMove: begin
                if (move_comp_q)   state_d = StPlay;
                else if (wait_hit) timeout = 1'b1;
            end
            StDown: begin
                if (down_comp_q) begin
                    state_d = StRem1;
                end else if (move_comp_q) begin
                    state_d = StPlay;
                    grav_d  = '0;
                end else if (wait_hit) begin
                    timeout = 1'b1;
                end
            end
            StRem1: state_d = StRem2;
            StRem2: begin
                if (rem2_fin_q)    state_d = StShift;
                else if (wait_hit) timeout = 1'b1;
            end
            StShift: begin
                if (shift_fin_q)   state_d = StGen;
                else if (wait_hit) timeout = 1'b1;
            end
            StOver: begin
                if (start && !start_prev_q) state_d = StGen;
            end
            default: state_d = StIdle;
        endcase
        if (timeout) begin
            state_d = StOver;
            err_d   = 1'b1;
        end
        wait_d = (!wait_active || state_d != state_q) ? '0 : wait_q + 1'b1;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q      <= StIdle;
            btn_q        <= '0;
            btn_prev_q   <= '0;
            start_prev_q <= 1'b0;
            move_comp_q  <= 1'b0;
            down_comp_q  <= 1'b0;
            rem2_fin_q   <= 1'b0;
            shift_fin_q  <= 1'b0;
            grav_q       <= '0;
            wait_q       <= '0;
            chk_q        <= 1'b0;
            dir_q        <= '0;
            auto_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            btn_q        <= {U, D, L, R};
            btn_prev_q   <= btn_q;
            start_prev_q <= start;
            // Completion flags only register inside their own wait state.
            move_comp_q  <= move_comp & ((state_q == StMove) || (state_q == StDown));
            down_comp_q  <= down_comp & (state_q == StDown);
            rem2_fin_q   <= remove_2_finish & (state_q == StRem2);
            shift_fin_q  <= shift_finish & (state_q == StShift);
            grav_q       <= grav_d;
            wait_q       <= wait_d;
            chk_q        <= chk_d;
            dir_q        <= dir_d;
            auto_q       <= auto_d;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            gen_random   <= 1'b0;
            isdie        <= 1'b0;
            moveT        <= 1'b0;
            move_down    <= 1'b0;
            remove_1     <= 1'b0;
            remove_2     <= 1'b0;
            shift        <= 1'b0;
            {u, d, l, r} <= 4'b0000;
            stop         <= 1'b1;
            auto_down    <= 1'b0;
            game_over    <= 1'b0;
            err          <= 1'b0;
        end else begin
            gen_random   <= (state_d == StGen);
            isdie        <= (state_d == StChk);
            moveT        <= (state_d == StMove);
            move_down    <= (state_d == StDown);
            remove_1     <= (state_d == StRem1);
            remove_2     <= (state_d == StRem2);
            shift        <= (state_d == StShift);
            {u, d, l, r} <= (state_d == StMove || state_d == StDown) ? dir_d : 4'b0000;
            stop         <= (state_d == StIdle) || (state_d == StOver) ||
                            ((state_d == StPlay) && pause);
            auto_down    <= (state_d == StDown) && auto_d;
            game_over    <= (state_d == StOver);
            err          <= err_d;
        end
    end

endmodule
